// File: rtl/led_anim_pkg.sv
// Shared encodings, FSM state constants and the LED bar pattern for the led_anim_ctrl sequencer.
package led_anim_pkg;

    localparam int FRAMES = 32;
    localparam int LEDS   = 16;
    localparam int FM_W   = $clog2(FRAMES);

    localparam logic [1:0] MODE_STOP = 2'b00;
    localparam logic [1:0] MODE_SLOW = 2'b01;
    localparam logic [1:0] MODE_MED  = 2'b10;
    localparam logic [1:0] MODE_FAST = 2'b11;

    typedef logic [1:0] anim_state_t;
    localparam anim_state_t IDLE = 2'd0;
    localparam anim_state_t RUN  = 2'd1;
    localparam anim_state_t WAIT = 2'd2;

    // Fill count rises 0..16 then drains back down; the lit LEDs grow from the MSB.
    function automatic logic [LEDS-1:0] bar_pattern(input logic [FM_W-1:0] n);
        logic [5:0] c;
        c = (n <= 5'd16) ? {1'b0, n} : (6'd32 - {1'b0, n});
        return ~(16'hFFFF >> c);
    endfunction

endpackage

// File: rtl/led_anim_ctrl_sw_debounce.sv
// Two-flop synchroniser plus stability counter: the output takes a new switch value
// only after it has been seen unchanged for DEB_CYCLES consecutive cycles.
module sw_debounce #(
    parameter int W          = 2,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sw_in,
    output logic [W-1:0] sw_out
);

    localparam int DW = $clog2(DEB_CYCLES + 1);

    logic [W-1:0]  sync1_r;
    logic [W-1:0]  sync2_r;
    logic [W-1:0]  cand_r;
    logic [W-1:0]  out_r;
    logic [DW-1:0] cnt_r;

    // Bring the asynchronous switches into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= {W{1'b0}};
            sync2_r <= {W{1'b0}};
        end else begin
            sync1_r <= sw_in;
            sync2_r <= sync1_r;
        end
    end

    // The cycle a new candidate appears already counts as its first stable cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_r <= {W{1'b0}};
            cnt_r  <= {DW{1'b0}};
            out_r  <= {W{1'b0}};
        end else if (sync2_r != cand_r) begin
            cand_r <= sync2_r;
            cnt_r  <= DW'(1);
        end else if (cnt_r >= DW'(DEB_CYCLES - 1)) begin
            out_r  <= cand_r;
        end else begin
            cnt_r  <= cnt_r + DW'(1);
        end
    end

    assign sw_out = out_r;

endmodule

// File: rtl/led_anim_ctrl.sv
// Frame sequencer for the 16-LED bar animation: debounced speed switches, frame tick timer
// and a valid/ready frame FSM. Defining LED_ANIM_STEP_EN adds the single-step input.
module led_anim_ctrl
    import led_anim_pkg::*;
#(
    parameter int CNT_W      = 27,
    parameter int T_SLOW     = 100000000,
    parameter int T_MED      = 50000000,
    parameter int T_FAST     = 20000000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sw0,
    input  logic            sw1,
`ifdef LED_ANIM_STEP_EN
    input  logic            step,
`endif
    input  logic            frame_ready,
    output logic            frame_valid,
    output logic [FM_W-1:0] fm_no,
    output logic [LEDS-1:0] frame,
    output logic [1:0]      mode,
    output logic            overrun
);

    logic [1:0]      mode_s;
    logic [1:0]      mode_q_r;
    logic            mode_chg_s;
    logic [CNT_W-1:0] period_m1_s;
    logic [CNT_W-1:0] cnt_r;
    logic            tick_s;
    logic            step_edge_s;
    anim_state_t     state_r;
    anim_state_t     state_nx_s;
    logic            adv_s;
    logic [FM_W-1:0] fm_no_r;
    logic [LEDS-1:0] frame_r;
    logic            valid_r;
    logic            overrun_r;

    sw_debounce #(
        .W          (2),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_sw_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .sw_in  ({sw0, sw1}),
        .sw_out (mode_s)
    );

    // Reload value for the tick counter in the current mode.
    always_comb begin
        case (mode_s)
            MODE_SLOW: period_m1_s = CNT_W'(T_SLOW - 1);
            MODE_MED:  period_m1_s = CNT_W'(T_MED - 1);
            MODE_FAST: period_m1_s = CNT_W'(T_FAST - 1);
            MODE_STOP: period_m1_s = {CNT_W{1'b0}};
            default:   period_m1_s = {CNT_W{1'b0}};
        endcase
    end

    assign mode_chg_s = (mode_s != mode_q_r);
    assign tick_s     = (cnt_r == {CNT_W{1'b0}}) && (mode_s != MODE_STOP) && !mode_chg_s;

    // Tick timer: restarts a full period on every mode change so the first tick is P cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q_r <= MODE_STOP;
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            mode_q_r <= mode_s;
            if (mode_chg_s || tick_s) begin
                cnt_r <= period_m1_s;
            end else if (mode_s != MODE_STOP) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

`ifdef LED_ANIM_STEP_EN
    logic [2:0] step_sh_r;

    // Synchronise the step button and keep one extra stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_sh_r <= 3'b000;
        end else begin
            step_sh_r <= {step_sh_r[1:0], step};
        end
    end

    assign step_edge_s = step_sh_r[1] & ~step_sh_r[2];
`else
    assign step_edge_s = 1'b0;
`endif

    // Frame FSM next state; adv_s marks the cycle a new frame is issued.
    always_comb begin
        state_nx_s = state_r;
        adv_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (mode_s != MODE_STOP) begin
                    state_nx_s = RUN;
                end else if (step_edge_s) begin
                    adv_s      = 1'b1;
                    state_nx_s = WAIT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (tick_s) begin
                    adv_s      = 1'b1;
                    state_nx_s = WAIT;
                end else if (mode_s == MODE_STOP) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            WAIT: begin
                if (frame_ready) begin
                    state_nx_s = (mode_s == MODE_STOP) ? IDLE : RUN;
                end else begin
                    state_nx_s = WAIT;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Frame registers: index and pattern change together with frame_valid rising.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            fm_no_r   <= {FM_W{1'b0}};
            frame_r   <= {LEDS{1'b0}};
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (adv_s) begin
                fm_no_r <= fm_no_r + 5'd1;
                frame_r <= bar_pattern(fm_no_r + 5'd1);
                valid_r <= 1'b1;
            end else if ((state_r == WAIT) && frame_ready) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
            if ((state_r == WAIT) && tick_s) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign frame_valid = valid_r;
    assign fm_no       = fm_no_r;
    assign frame       = frame_r;
    assign mode        = mode_s;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_led_anim_ctrl.sv
// Self-checking bench for led_anim_ctrl: directed scenarios plus random switch/ready traffic
// compared every cycle against a behavioural model of the animation rules.
module tb_led_anim_ctrl;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sw0 = 1'b0;
    logic        sw1 = 1'b0;
    logic        step = 1'b0;
    logic        frame_ready = 1'b0;
    logic        frame_valid;
    logic [4:0]  fm_no;
    logic [15:0] frame;
    logic [1:0]  mode;
    logic        overrun;

    led_anim_ctrl #(
        .CNT_W(27), .T_SLOW(40), .T_MED(20), .T_FAST(8), .DEB_CYCLES(DEB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sw0(sw0), .sw1(sw1),
`ifdef LED_ANIM_STEP_EN
        .step(step),
`endif
        .frame_ready(frame_ready), .frame_valid(frame_valid), .fm_no(fm_no),
        .frame(frame), .mode(mode), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [1:0]  m_mode;
    logic [4:0]  m_fm;
    logic [15:0] m_frame;
    logic        m_valid, m_busy, m_ovr;
    int          m_ref;
    logic [1:0]  swq[$];
    logic        stq[$];

    function automatic int period(input logic [1:0] md);
        case (md)
            2'b01:   return 40;
            2'b10:   return 20;
            2'b11:   return 8;
            default: return 0;
        endcase
    endfunction

    function automatic logic [15:0] bar(input int n);
        int c;
        logic [15:0] b;
        c = (n <= 16) ? n : 32 - n;
        b = 16'h0000;
        for (int i = 0; i < c; i++) b[15-i] = 1'b1;
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 2'b00; m_fm = 5'd0; m_frame = 16'h0000;
        m_valid = 1'b0; m_busy = 1'b0; m_ovr = 1'b0; m_ref = 0;
        swq = {};
        stq = {};
        repeat (DEB + 2) swq.push_back(2'b00);
        repeat (4) stq.push_back(1'b0);
    endtask

    task automatic advance();
        m_fm = m_fm + 5'd1;
        m_frame = bar(int'(m_fm));
        m_valid = 1'b1;
        m_busy = 1'b1;
    endtask

    // One clock: update the model from the inputs the DUT sampled, then compare all outputs.
    task automatic tick_clk();
        logic tk, st_ev, was_busy, same;
        @(posedge clk);
        cyc++;
        tk = (m_mode != 2'b00) && (cyc == m_ref + period(m_mode));
        stq.push_back(step);
        void'(stq.pop_front());
`ifdef LED_ANIM_STEP_EN
        st_ev = stq[1] && !stq[0] && (m_mode == 2'b00) && !m_busy;
`else
        st_ev = 1'b0;
`endif
        was_busy = m_busy;
        if (was_busy && frame_ready) begin
            m_valid = 1'b0;
            m_busy = 1'b0;
        end
        if (tk) begin
            if (was_busy) m_ovr = 1'b1;
            else advance();
            m_ref = cyc;
        end
        if (st_ev) advance();
        swq.push_back({sw0, sw1});
        void'(swq.pop_front());
        same = 1'b1;
        for (int i = 1; i < DEB; i++) if (swq[i] != swq[0]) same = 1'b0;
        if (same && swq[0] != m_mode) begin
            m_mode = swq[0];
            m_ref = cyc + 1;
        end
        #1;
        check("fm_no", 32'(fm_no), 32'(m_fm));
        check("frame", 32'(frame), 32'(m_frame));
        check("frame_valid", 32'(frame_valid), 32'(m_valid));
        check("mode", 32'(mode), 32'(m_mode));
        check("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick_clk();
    endtask

    task automatic wait_valid(input int maxc, input string tag);
        int k;
        k = 0;
        while (!frame_valid && k < maxc) begin
            tick_clk();
            k++;
        end
        check(tag, 32'(frame_valid), 32'd1);
    endtask

    initial begin
        int last_rise, rises, k;
        logic prev_v;
        model_reset();

        // Reset state
        #2 rst_n = 1'b0;
        #2;
        check("rst_fm", 32'(fm_no), 32'd0);
        check("rst_valid", 32'(frame_valid), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        run(5);

        // Debounce: a 3-cycle glitch is rejected, a stable value lands after 2+DEB cycles
        {sw0, sw1} = 2'b11;
        run(3);
        {sw0, sw1} = 2'b00;
        run(10);
        check("glitch_mode", 32'(mode), 32'd0);
        {sw0, sw1} = 2'b11;
        run(2 + DEB - 1);
        check("deb_early", 32'(mode), 32'd0);
        run(1);
        check("deb_latency", 32'(mode), 32'd3);

        // Fast mode, ready tied high: pulse every 8 cycles, full fill/drain cycle
        frame_ready = 1'b1;
        last_rise = -1;
        prev_v = 1'b0;
        for (int i = 0; i < 8 * 34 + 12; i++) begin
            tick_clk();
            if (frame_valid && !prev_v) begin
                if (last_rise >= 0) check("tick_spacing", 32'(cyc - last_rise), 32'd8);
                last_rise = cyc;
                if (fm_no == 5'd16) check("frame_16", 32'(frame), 32'hFFFF);
                if (fm_no == 5'd17) check("frame_17", 32'(frame), 32'hFFFE);
                if (fm_no == 5'd31) check("frame_31", 32'(frame), 32'h8000);
                if (fm_no == 5'd0)  check("frame_0", 32'(frame), 32'h0000);
            end
            prev_v = frame_valid;
        end

        // Asynchronous reset mid-run at frame 7
        k = 0;
        while (fm_no != 5'd7 && k < 400) begin
            tick_clk();
            k++;
        end
        check("reach_fm7", 32'(fm_no), 32'd7);
        #2 rst_n = 1'b0;
        {sw0, sw1} = 2'b00;
        #1;
        check("arst_fm", 32'(fm_no), 32'd0);
        check("arst_frame", 32'(frame), 32'd0);
        check("arst_valid", 32'(frame_valid), 32'd0);
        check("arst_mode", 32'(mode), 32'd0);
        check("arst_overrun", 32'(overrun), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        run(10);

        // Backpressure: frame held, overrun set, next advance only after ready
        frame_ready = 1'b0;
        {sw0, sw1} = 2'b11;
        wait_valid(40, "bp_first_valid");
        check("bp_first_fm", 32'(fm_no), 32'd1);
        run(20);
        check("bp_hold_valid", 32'(frame_valid), 32'd1);
        check("bp_hold_fm", 32'(fm_no), 32'd1);
        check("bp_overrun", 32'(overrun), 32'd1);
        frame_ready = 1'b1;
        run(1);
        check("bp_release", 32'(frame_valid), 32'd0);
        wait_valid(20, "bp_next_valid");
        check("bp_next_fm", 32'(fm_no), 32'd2);

        // Stop while a frame is pending: handshake completes, then no more advances
        frame_ready = 1'b0;
        {sw0, sw1} = 2'b00;
        run(DEB + 4);
        check("stop_mode", 32'(mode), 32'd0);
        check("stop_pending", 32'(frame_valid), 32'd1);
        frame_ready = 1'b1;
        run(1);
        check("stop_handshake", 32'(frame_valid), 32'd0);
        run(100);
        check("stop_frozen_fm", 32'(fm_no), 32'd2);

`ifdef LED_ANIM_STEP_EN
        // Single-step in stop mode, ignored while running
        rises = 0;
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            for (int i = 0; i < 2; i++) begin tick_clk(); if (frame_valid) rises++; end
            step = 1'b0;
            for (int i = 0; i < 5; i++) begin tick_clk(); if (frame_valid) rises++; end
        end
        check("step_handshakes", 32'(rises), 32'd3);
        check("step_fm", 32'(fm_no), 32'd5);
        {sw0, sw1} = 2'b01;
        run(12);
        step = 1'b1;
        run(2);
        step = 1'b0;
        run(6);
        check("step_ignored", 32'(fm_no), 32'd5);
        {sw0, sw1} = 2'b00;
        run(20);
`endif

        // Random switch and ready traffic against the model
        while (cyc < 3000) begin
            int dur;
            {sw0, sw1} = 2'($urandom_range(0, 3));
            dur = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(20, 120);
            for (int i = 0; i < dur; i++) begin
                frame_ready = ($urandom_range(0, 9) < 7);
                tick_clk();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
